// File: rtl/random_pulse_gen_multi.sv
// NCH-channel random pulse generator: per-channel Galois LFSR, density threshold, programmable length.
// Define RPG_GAP_EN to add a GAP state that forces GAP_CYC low cycles after every pulse.
module random_pulse_gen_multi #(
   parameter int                NCH     = 4,
   parameter int                LFSR_W  = 16,
   parameter logic [LFSR_W-1:0] TAPS    = 16'hB400,
   parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
   parameter int                PW_W    = 4,
   parameter int                GAP_CYC = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic [7:0]      density,
   input  logic [PW_W-1:0] pulse_len,
   output logic [NCH-1:0]  pulse,
   output logic [NCH-1:0]  busy,
   output logic [15:0]     trig_cnt
);

   // One counter serves both pulse length and gap length, so size it for the larger.
   localparam int GAP_BITS = (GAP_CYC < 1) ? 1 : $clog2(GAP_CYC + 1);
   localparam int CNT_W    = (PW_W > GAP_BITS) ? PW_W : GAP_BITS;

   typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} state_t;

   function automatic logic [LFSR_W-1:0] seed_of(input int idx);
      logic [LFSR_W-1:0] r;
      r = SEED;
      for (int k = 0; k < idx; k++) begin
         r = {r[LFSR_W-2:0], r[LFSR_W-1]};
      end
      if (r == '0) begin
         r = {{(LFSR_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   logic [NCH-1:0]  trig;
   logic [CNT_W-1:0] len_ext;

   assign len_ext = (pulse_len == '0) ? CNT_W'(1) : CNT_W'(pulse_len);

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         localparam logic [LFSR_W-1:0] SEED_I = seed_of(gi);

         logic [LFSR_W-1:0] lfsr_reg;
         logic [LFSR_W-1:0] lfsr_next;
         state_t            state_reg;
         logic [CNT_W-1:0]  cnt_reg;
         logic              pulse_reg;

         assign lfsr_next = {1'b0, lfsr_reg[LFSR_W-1:1]} ^ (lfsr_reg[0] ? TAPS : '0);
         assign trig[gi]  = (state_reg == IDLE) && ena && (lfsr_reg[7:0] < density);
         assign pulse[gi] = pulse_reg;
         assign busy[gi]  = (state_reg != IDLE);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               lfsr_reg  <= SEED_I;
               state_reg <= IDLE;
               cnt_reg   <= '0;
               pulse_reg <= 1'b0;
            end else begin
               if (ena) begin
                  lfsr_reg <= lfsr_next;
               end
               case (state_reg)
                  IDLE: begin
                     if (trig[gi]) begin
                        state_reg <= PULSE;
                        cnt_reg   <= len_ext;
                        pulse_reg <= 1'b1;
                     end
                  end
                  // Once started a pulse runs to completion regardless of ena.
                  PULSE: begin
                     if (cnt_reg == CNT_W'(1)) begin
                        pulse_reg <= 1'b0;
`ifdef RPG_GAP_EN
                        if (GAP_CYC > 0) begin
                           state_reg <= GAP;
                           cnt_reg   <= CNT_W'(GAP_CYC);
                        end else begin
                           state_reg <= IDLE;
                        end
`else
                        state_reg <= IDLE;
`endif
                     end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                     end
                  end
`ifdef RPG_GAP_EN
                  GAP: begin
                     if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= IDLE;
                     end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                     end
                  end
`endif
                  default: begin
                     state_reg <= IDLE;
                     pulse_reg <= 1'b0;
                  end
               endcase
            end
         end
      end
   endgenerate

   logic [3:0]  trig_pop;
   logic [16:0] trig_sum;
   logic [15:0] trig_cnt_reg;

   always_comb begin
      trig_pop = '0;
      for (int k = 0; k < NCH; k++) begin
         trig_pop = trig_pop + 4'(trig[k]);
      end
      trig_sum = {1'b0, trig_cnt_reg} + 17'(trig_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_cnt_reg <= '0;
      end else if (trig_sum[16]) begin
         trig_cnt_reg <= 16'hFFFF;
      end else begin
         trig_cnt_reg <= trig_sum[15:0];
      end
   end

   assign trig_cnt = trig_cnt_reg;

endmodule

// File: tb/tb_random_pulse_gen_multi.sv
// Bench for random_pulse_gen_multi: table of stimulus phases plus random segments,
// checked every cycle against a cycle-count model of pulse windows and LFSR sequences.
module tb_random_pulse_gen_multi;
   localparam int          NCH  = 4;
   localparam int          PW_W = 4;
   localparam logic [15:0] TAPS = 16'hB400;
   localparam logic [15:0] SEED = 16'hACE1;
`ifdef RPG_GAP_EN
   localparam int GAP = 4;
`else
   localparam int GAP = 0;
`endif
   localparam int MIN_LOW = GAP + 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            ena = 1'b0;
   logic [7:0]      density = '0;
   logic [PW_W-1:0] pulse_len = '0;
   logic [NCH-1:0]  pulse;
   logic [NCH-1:0]  busy;
   logic [15:0]     trig_cnt;

   random_pulse_gen_multi #(
      .NCH(NCH), .LFSR_W(16), .TAPS(TAPS), .SEED(SEED), .PW_W(PW_W), .GAP_CYC(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .density(density), .pulse_len(pulse_len),
      .pulse(pulse), .busy(busy), .trig_cnt(trig_cnt)
   );

   always #5 clk = ~clk;

   // Model: each channel is a window of high cycles [start+1, start+L] and busy until free_c.
   int unsigned m_lfsr [NCH];
   int          start_c[NCH], len_c[NCH], free_c[NCH];
   int          m_cnt, cyc;
   logic [NCH-1:0] exp_p, exp_b;

   int   hi_run[NCH], lo_run[NCH], want_w[NCH];
   bit   had_fall[NCH], prev_p[NCH];
   int   cur_w;
   bit   cur_quiet;
   int   n_vec, n_err;

   typedef struct {
      logic ena;
      int   density;
      int   len;
      int   cycles;
      logic quiet;   // expected: no new pulse may start in this phase
      int   width;   // expected width of every pulse started in this phase (0 = any)
   } vec_t;
   vec_t tbl[6];

   logic [NCH-1:0] trace_a[200];

   task automatic check(input string name, input logic [31:0] act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic int unsigned seed_of(input int i);
      int unsigned s;
      s = ((int'(SEED) << i) | (int'(SEED) >> (16 - i))) & 32'hFFFF;
      return (s == 0) ? 1 : s;
   endfunction

   task automatic model_reset();
      for (int ch = 0; ch < NCH; ch++) begin
         m_lfsr[ch]  = seed_of(ch);
         start_c[ch] = -1000;
         len_c[ch]   = 0;
         free_c[ch]  = 0;
         hi_run[ch]  = 0;
         lo_run[ch]  = 0;
         want_w[ch]  = 0;
         had_fall[ch] = 0;
         prev_p[ch]  = 0;
      end
      m_cnt = 0;
   endtask

   task automatic step();
      int l;
      l = (pulse_len == 0) ? 1 : int'(pulse_len);
      for (int ch = 0; ch < NCH; ch++) begin
         if (ena && cyc >= free_c[ch] && (m_lfsr[ch] & 32'hFF) < int'(density)) begin
            start_c[ch] = cyc;
            len_c[ch]   = l;
            free_c[ch]  = cyc + l + 1 + GAP;
            if (m_cnt < 32'hFFFF) m_cnt++;
         end
         if (ena) m_lfsr[ch] = (m_lfsr[ch] >> 1) ^ (((m_lfsr[ch] & 1) != 0) ? int'(TAPS) : 0);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int ch = 0; ch < NCH; ch++) begin
         exp_p[ch] = (cyc > start_c[ch]) && (cyc <= start_c[ch] + len_c[ch]);
         exp_b[ch] = (cyc < free_c[ch]);
      end
      check("pulse", 32'(pulse), int'(exp_p));
      check("busy", 32'(busy), int'(exp_b));
      check("trig_cnt", 32'(trig_cnt), m_cnt);
      for (int ch = 0; ch < NCH; ch++) begin
         if (pulse[ch] && !prev_p[ch]) begin
            if (cur_quiet) check("quiet_rise", 32'(1), 0);
            if (had_fall[ch]) check("min_low_ok", 32'(lo_run[ch] >= MIN_LOW), 1);
            want_w[ch] = cur_w;
            hi_run[ch] = 1;
         end else if (pulse[ch]) begin
            hi_run[ch]++;
         end else if (prev_p[ch]) begin
            if (want_w[ch] != 0) check("width", 32'(hi_run[ch]), want_w[ch]);
            had_fall[ch] = 1;
            lo_run[ch] = 1;
         end else begin
            lo_run[ch]++;
         end
         prev_p[ch] = pulse[ch];
      end
   endtask

   // Reset lands between clock edges, so the immediate drop checks the async path.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_pulse", 32'(pulse), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_trig_cnt", 32'(trig_cnt), 0);
      repeat (2) begin
         @(posedge clk);
         cyc++;
      end
      #3;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic run_phase(input logic e, input int d, input int len, input int n,
                            input logic quiet, input int width);
      ena       = e;
      density   = 8'(d);
      pulse_len = PW_W'(len);
      cur_quiet = quiet;
      cur_w     = width;
      repeat (n) step();
   endtask

   initial begin
      int  rlen;
      logic re, p0;
      bit  seen;
      n_vec = 0;
      n_err = 0;
      cyc = 0;
      model_reset();

      tbl[0] = '{1'b1,   0,  5, 2000, 1'b1,  0};
      tbl[1] = '{1'b1, 255,  3,  300, 1'b0,  3};
      tbl[2] = '{1'b1, 128,  0,  300, 1'b0,  1};
      tbl[3] = '{1'b0, 200,  2,   60, 1'b1,  0};
      tbl[4] = '{1'b1,  64,  7,  400, 1'b0,  7};
      tbl[5] = '{1'b1, 255, 15,  200, 1'b0, 15};

      // Power-up run, recorded for the later bit-for-bit replay after a mid-pulse reset.
      do_reset();
      ena = 1'b1; density = 8'd128; pulse_len = 4'd3; cur_quiet = 0; cur_w = 3;
      for (int k = 0; k < 200; k++) begin
         step();
         trace_a[k] = exp_p;
      end

      for (int v = 0; v < 6; v++) begin
         run_phase(tbl[v].ena, tbl[v].density, tbl[v].len, tbl[v].cycles,
                   tbl[v].quiet, tbl[v].width);
      end

      // ena drops during the 2nd cycle of a 4-cycle pulse on channel 0.
      ena = 1'b1; density = 8'd255; pulse_len = 4'd4; cur_quiet = 0; cur_w = 4;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         p0 = pulse[0];
         step();
         if (pulse[0] && !p0) seen = 1;
      end
      check("ena_rise_seen", 32'(seen), 1);
      step();
      ena = 1'b0;
      cur_quiet = 1;
      step(); check("ena_hold1", 32'(pulse[0]), 1);
      step(); check("ena_hold2", 32'(pulse[0]), 1);
      step(); check("ena_done", 32'(pulse[0]), 0);
      repeat (40) step();

      for (int s = 0; s < 15; s++) begin
         re   = ($urandom_range(0, 3) != 0);
         rlen = $urandom_range(0, 15);
         run_phase(re, $urandom_range(0, 255), rlen, $urandom_range(20, 120),
                   !re, re ? ((rlen == 0) ? 1 : rlen) : 0);
      end

      // Reset in the middle of a pulse, then replay the power-up run.
      ena = 1'b1; density = 8'd255; pulse_len = 4'd6; cur_quiet = 0; cur_w = 6;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         step();
         if (pulse != '0) seen = 1;
      end
      check("pre_reset_pulse_seen", 32'(seen), 1);
      do_reset();
      ena = 1'b1; density = 8'd128; pulse_len = 4'd3; cur_quiet = 0; cur_w = 3;
      for (int k = 0; k < 200; k++) begin
         step();
         check("replay", 32'(pulse), int'(trace_a[k]));
      end

      // Drive the trigger counter into saturation and hold it there.
      do_reset();
      run_phase(1'b1, 255, 0, 36000, 1'b0, 1);
      check("trig_cnt_sat", 32'(trig_cnt), m_cnt);
      run_phase(1'b1, 255, 0, 50, 1'b0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
